// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control front end for the pipelined MIPS core.
// Stretches and synchronises core reset, gates core_en for run/step/run-N, detects halt and watchdog.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned HALT_REPEAT = 3,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_rst,
  input  logic [1:0]       mode,
  input  logic             go,
  input  logic             stop,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic [PC_W-1:0]  core_pc,
  input  logic             core_pc_valid,
  output logic             core_reset,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout
);

  typedef enum logic [2:0] {S_RST, S_IDLE, S_RUN, S_STEP, S_RUNN, S_HALT} state_t;
  typedef enum logic [1:0] {M_RUN, M_STEP, M_RUNN, M_HOLD} mode_t;

  localparam int unsigned       ST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ST_W-1:0]   ST_LAST = ST_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  localparam int unsigned       RP_W    = $clog2(HALT_REPEAT + 1);
  localparam logic [RP_W-1:0]   RP_LAST = RP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  TO_LIM  = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  mode_t            go_mode;
  logic [1:0]       sync;
  logic [ST_W-1:0]  stretch;
  logic [RP_W-1:0]  rep;
  logic [RP_W-1:0]  rep_inc;
  logic [PC_W-1:0]  last_pc;
  logic             have_last;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_inc;
  logic             rel, pc_chk, pc_same, halt_hit, wd_hit, stop_hit, runn_end;
  logic             run_st, busy_nxt, done_nxt;

  always_comb begin
    go_mode  = mode_t'(mode);
    run_st   = (state == S_RUN) || (state == S_RUNN);
    if (RST_CYCLES == 0) rel = sync[0];
    else                 rel = sync[1] && (stretch == ST_LAST);
    pc_chk   = core_en && core_pc_valid;
    pc_same  = have_last && (core_pc == last_pc);
    rep_inc  = rep + 1'b1;
    halt_hit = pc_chk && pc_same && (rep_inc == RP_LAST);
    cnt_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
    wd_hit   = (TO_LIM != '0) && core_en && run_st && (cnt_inc >= TO_LIM);
    stop_hit = stop && run_st;
    runn_end = (state == S_RUNN) && (remaining == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RST;
    else        state <= state_nxt;
  end

  // Exit priority for enabled states: halt > timeout > stop > step/run-N completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RST:  if (rel) state_nxt = S_IDLE;
      S_IDLE: if (go) begin
        unique case (go_mode)
          M_RUN:  state_nxt = S_RUN;
          M_STEP: state_nxt = S_STEP;
          M_RUNN: if (n_cycles != '0) state_nxt = S_RUNN;
          M_HOLD: state_nxt = S_IDLE;
        endcase
      end
      S_RUN, S_STEP, S_RUNN: begin
        if (halt_hit || wd_hit)              state_nxt = S_HALT;
        else if (stop_hit)                   state_nxt = S_IDLE;
        else if (state == S_STEP || runn_end) state_nxt = S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
    if (soft_rst) state_nxt = S_RST;
  end

  always_comb begin
    busy     = (state == S_RUN) || (state == S_STEP) || (state == S_RUNN);
    busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_STEP) || (state_nxt == S_RUNN);
    done_nxt = !soft_rst &&
               (((state == S_IDLE) && go && (go_mode == M_RUNN) && (n_cycles == '0)) ||
                (busy && (state_nxt == S_IDLE)));
  end

  // The synchroniser stays at 1 after power-on release, so a soft restart only re-runs the stretch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync       <= '0;
      stretch    <= '0;
      core_reset <= 1'b1;
      core_en    <= 1'b0;
      done       <= 1'b0;
      cycle_cnt  <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      rep        <= '0;
      last_pc    <= '0;
      have_last  <= 1'b0;
      remaining  <= '0;
    end else begin
      sync    <= {sync[0], 1'b1};
      core_en <= busy_nxt;
      done    <= done_nxt;
      if (soft_rst) begin
        core_reset <= 1'b1;
        stretch    <= '0;
        cycle_cnt  <= '0;
        halted     <= 1'b0;
        timeout    <= 1'b0;
        rep        <= '0;
        have_last  <= 1'b0;
        remaining  <= '0;
      end else begin
        if (state == S_RST) begin
          if (rel) begin
            core_reset <= 1'b0;
            stretch    <= '0;
          end else if (sync[1]) begin
            stretch <= stretch + 1'b1;
          end
        end
        if (core_en) cycle_cnt <= cnt_inc;
        if (halt_hit)    halted  <= 1'b1;
        else if (wd_hit) timeout <= 1'b1;
        if (pc_chk) begin
          last_pc   <= core_pc;
          have_last <= 1'b1;
          rep       <= pc_same ? rep_inc : '0;
        end
        if ((state == S_IDLE) && go && (go_mode == M_RUNN)) remaining <= n_cycles;
        else if ((state == S_RUNN) && core_en)               remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed table, multi-cycle sequences and a
// randomized run compared against a transaction-level model of the run-control rules.
module tb_cpu_run_ctrl;
  localparam int unsigned RC = 4;
  localparam int unsigned HR = 3;
  localparam int unsigned TO = 100;
  localparam longint      CNT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, soft_rst, go, stop, pcv;
  logic [1:0]  mode;
  logic [31:0] n_cycles, pc;
  logic [3:0]  n4;
  logic        core_reset, core_en, busy, done, halted, timeout;
  logic [31:0] cycle_cnt;
  logic        s_rst, s_en, s_busy, s_done, s_halt, s_to;
  logic [3:0]  s_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RST_CYCLES(RC), .CNT_W(32), .PC_W(32), .HALT_REPEAT(HR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .mode(mode), .go(go), .stop(stop),
    .n_cycles(n_cycles), .core_pc(pc), .core_pc_valid(pcv), .core_reset(core_reset),
    .core_en(core_en), .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .halted(halted),
    .timeout(timeout));

  cpu_run_ctrl #(.RST_CYCLES(RC), .CNT_W(4), .PC_W(32), .HALT_REPEAT(HR), .TIMEOUT(0)) u_sat (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .mode(mode), .go(go), .stop(stop),
    .n_cycles(n4), .core_pc(pc), .core_pc_valid(pcv), .core_reset(s_rst),
    .core_en(s_en), .cycle_cnt(s_cnt), .busy(s_busy), .done(s_done), .halted(s_halt),
    .timeout(s_to));

  // Reference model: edges left in reset, enabled flag with a job kind and remaining budget,
  // and the history of valid PCs seen while enabled.
  int          m_rst_left;
  bit          m_en, m_done, m_halt, m_to;
  int          m_kind;   // 0 run, 1 step, 2 run-n
  longint      m_left;
  longint      m_cnt;
  logic [31:0] pcs[$];

  function automatic void model_reset();
    m_rst_left = 2 + RC;
    m_en = 0; m_done = 0; m_halt = 0; m_to = 0;
    m_kind = 0; m_left = 0; m_cnt = 0;
    pcs.delete();
  endfunction

  function automatic void model_step();
    longint c;
    int     run;
    bit     halt_now;
    if (!reset) begin model_reset(); return; end
    if (soft_rst) begin
      model_reset();
      m_rst_left = RC;
      return;
    end
    m_done = 0;
    if (m_rst_left > 0) begin m_rst_left--; return; end
    if (m_halt || m_to) return;
    if (m_en) begin
      c = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      halt_now = 0;
      if (pcv) begin
        run = 0;
        for (int i = pcs.size() - 1; i >= 0; i--) begin
          if (pcs[i] == pc) run++;
          else break;
        end
        pcs.push_back(pc);
        if (pcs.size() > HR) void'(pcs.pop_front());
        halt_now = (run >= HR);
      end
      m_cnt = c;
      if (halt_now) begin m_halt = 1; m_en = 0; end
      else if (TO != 0 && m_kind != 1 && c >= TO) begin m_to = 1; m_en = 0; end
      else if (stop && m_kind != 1) begin m_en = 0; m_done = 1; end
      else if (m_kind == 1) begin m_en = 0; m_done = 1; end
      else if (m_kind == 2) begin
        m_left--;
        if (m_left == 0) begin m_en = 0; m_done = 1; end
      end
    end else if (go) begin
      case (mode)
        2'd0: begin m_en = 1; m_kind = 0; end
        2'd1: begin m_en = 1; m_kind = 1; end
        2'd2: begin
          if (n_cycles == 0) m_done = 1;
          else begin m_en = 1; m_kind = 2; m_left = n_cycles; end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    logic [37:0] act, exp;
    act = {core_reset, core_en, busy, done, halted, timeout, cycle_cnt};
    exp = {m_rst_left > 0, m_en, m_en, m_done, m_halt, m_to, m_cnt[31:0]};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (rst,en,busy,done,halt,to,cnt)", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    soft_rst = 0; go = 0; mode = 2'd0; stop = 0; n_cycles = 0; n4 = 0; pc = 0; pcv = 0;
  endtask

  task automatic soft_restart();
    soft_rst = 1;
    cycle();
    soft_rst = 0;
    repeat (RC) cycle();
    check_model("soft_restart");
  endtask

  typedef struct {
    bit s, g; bit [1:0] md; bit sp; int unsigned n; bit [31:0] p; bit pv;
    bit er, ee, ed, eh; int unsigned ec;
  } vec_t;

  function automatic vec_t v(input bit s, input bit g, input bit [1:0] md, input bit sp,
                             input int unsigned n, input bit [31:0] p, input bit pv,
                             input bit er, input bit ee, input bit ed, input bit eh,
                             input int unsigned ec);
    vec_t r;
    r.s = s; r.g = g; r.md = md; r.sp = sp; r.n = n; r.p = p; r.pv = pv;
    r.er = er; r.ee = ee; r.ed = ed; r.eh = eh; r.ec = ec;
    return r;
  endfunction

  vec_t tbl[30];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cnt, done_cnt;
    logic [37:0] act, exp;

    //          s g md sp n  pc      pv | rst en done halt cnt
    tbl[0]  = v(0,1,1,0,0,'h100,1, 0,1,0,0,0);   // STEP x3
    tbl[1]  = v(0,0,0,0,0,'h100,1, 0,0,1,0,1);
    tbl[2]  = v(0,1,1,0,0,'h104,1, 0,1,0,0,1);
    tbl[3]  = v(0,0,0,0,0,'h104,1, 0,0,1,0,2);
    tbl[4]  = v(0,1,1,0,0,'h108,1, 0,1,0,0,2);
    tbl[5]  = v(0,0,0,0,0,'h108,1, 0,0,1,0,3);
    tbl[6]  = v(0,0,0,0,0,0,0,     0,0,0,0,3);
    tbl[7]  = v(0,1,2,0,0,0,0,     0,0,1,0,3);   // RUN-N with zero budget
    tbl[8]  = v(0,0,0,0,0,0,0,     0,0,0,0,3);
    tbl[9]  = v(0,1,3,0,0,0,0,     0,0,0,0,3);   // HOLD ignored
    tbl[10] = v(0,1,2,0,2,'h200,1, 0,1,0,0,3);   // RUN-N 2
    tbl[11] = v(0,0,0,0,0,'h204,1, 0,1,0,0,4);
    tbl[12] = v(0,0,0,0,0,'h208,1, 0,0,1,0,5);
    tbl[13] = v(0,0,0,0,0,0,0,     0,0,0,0,5);
    tbl[14] = v(0,1,0,0,0,0,0,     0,1,0,0,5);   // RUN then stop
    tbl[15] = v(0,0,0,0,0,'h300,1, 0,1,0,0,6);
    tbl[16] = v(0,0,0,1,0,'h304,1, 0,0,1,0,7);
    tbl[17] = v(0,0,0,1,0,0,0,     0,0,0,0,7);   // stop in IDLE ignored
    tbl[18] = v(0,1,0,0,0,0,0,     0,1,0,0,7);   // RUN to halt, invalid PC holds
    tbl[19] = v(0,0,0,0,0,'h400,1, 0,1,0,0,8);
    tbl[20] = v(0,0,0,0,0,'h400,0, 0,1,0,0,9);
    tbl[21] = v(0,0,0,0,0,'h400,1, 0,1,0,0,10);
    tbl[22] = v(0,0,0,0,0,'h400,1, 0,1,0,0,11);
    tbl[23] = v(0,0,0,0,0,'h400,1, 0,0,0,1,12);
    tbl[24] = v(0,1,1,0,0,0,0,     0,0,0,1,12);  // go ignored while halted
    tbl[25] = v(1,0,0,0,0,0,0,     1,0,0,0,0);   // soft restart
    tbl[26] = v(0,1,0,0,0,0,0,     1,0,0,0,0);   // go ignored in reset
    tbl[27] = v(0,0,0,0,0,0,0,     1,0,0,0,0);
    tbl[28] = v(0,0,0,0,0,0,0,     1,0,0,0,0);
    tbl[29] = v(0,0,0,0,0,0,0,     0,0,0,0,0);

    idle_inputs();
    reset = 0;
    model_reset();

    // T1: power-on reset and stretch, then restart of the stretch mid-way
    repeat (3) begin cycle(); check_model("t1_in_reset"); end
    reset = 1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("t1_core_reset", core_reset, (i < 6));
      check_model("t1_stretch");
    end
    reset = 0;
    #1;
    model_reset();
    check_model("t1_rst_assert");
    cycle();
    reset = 1;
    repeat (3) cycle();
    reset = 0;
    #1;
    model_reset();
    check_model("t1_mid_reassert");
    cycle();
    reset = 1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("t1_restart_core_reset", core_reset, (i < 6));
    end

    // Directed table
    foreach (tbl[i]) begin
      soft_rst = tbl[i].s; go = tbl[i].g; mode = tbl[i].md; stop = tbl[i].sp;
      n_cycles = tbl[i].n; n4 = n_cycles[3:0]; pc = tbl[i].p; pcv = tbl[i].pv;
      cycle();
      act = {core_reset, core_en, busy, done, halted, timeout, cycle_cnt};
      exp = {tbl[i].er, tbl[i].ee, tbl[i].ee, tbl[i].ed, tbl[i].eh, 1'b0, tbl[i].ec};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL table_row%0d: got %h expected %h", i, act, exp);
      end
    end
    idle_inputs();

    // T3: RUN-N for 10 cycles
    go = 1; mode = 2'd2; n_cycles = 10; n4 = 4'd10;
    cycle();
    go = 0;
    en_cnt = int'(core_en);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      pc = 32'h2000 + 32'(i) * 4; pcv = 1;
      cycle();
      en_cnt += int'(core_en);
      done_cnt += int'(done);
      if (done && core_en) chk("t3_done_with_en", 1, 0);
    end
    chk("t3_en_cycles", en_cnt, 10);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_cycle_cnt", cycle_cnt, 10);
    idle_inputs();

    // T4: self-loop halt at constant PC
    soft_restart();
    go = 1; mode = 2'd0; pc = 32'h0000_3010; pcv = 1;
    cycle();
    go = 0;
    for (int i = 0; i < 20 && !halted; i++) cycle();
    chk("t4_halted", halted, 1);
    chk("t4_cycle_cnt", cycle_cnt, 1 + HR);
    chk("t4_core_en", core_en, 0);
    go = 1; mode = 2'd1;
    cycle();
    chk("t4_go_ignored", {core_en, busy}, 2'b00);
    go = 0;
    soft_rst = 1;
    cycle();
    soft_rst = 0;
    chk("t4_soft_clears", {halted, core_reset}, 2'b01);
    repeat (RC) cycle();
    idle_inputs();

    // T5: watchdog fires at 100 and beats a same-edge stop
    go = 1; mode = 2'd0;
    cycle();
    go = 0;
    for (int i = 0; i < 150 && !timeout; i++) begin
      pc = 32'h1000 + 32'(i) * 4; pcv = 1;
      stop = (m_cnt == TO - 1);
      cycle();
    end
    stop = 0;
    chk("t5_timeout", timeout, 1);
    chk("t5_cycle_cnt", cycle_cnt, TO);
    chk("t5_en_done", {core_en, done, halted}, 3'b000);
    cycle();
    chk("t5_no_done", {done, busy}, 2'b00);
    go = 1;
    cycle();
    chk("t5_go_ignored", core_en, 0);
    idle_inputs();

    // T6: 4-bit counter saturates
    soft_restart();
    go = 1; mode = 2'd0;
    cycle();
    go = 0;
    for (int i = 0; i < 20; i++) begin
      pc = 32'h5000 + 32'(i) * 4; pcv = 1;
      cycle();
    end
    stop = 1;
    cycle();
    stop = 0;
    chk("t6_sat_cnt", s_cnt, 15);
    chk("t6_sat_en", s_en, 0);
    done_cnt = int'(s_done);
    repeat (3) begin cycle(); done_cnt += int'(s_done); end
    chk("t6_done_once", done_cnt, 1);
    idle_inputs();

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      soft_rst = ($urandom_range(99) < 3);
      go       = ($urandom_range(3) == 0);
      mode     = 2'($urandom_range(3));
      stop     = ($urandom_range(19) == 0);
      n_cycles = $urandom_range(6);
      n4       = n_cycles[3:0];
      pc       = 32'($urandom_range(3)) << 2;
      pcv      = ($urandom_range(9) < 7);
      cycle();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
